// File: rtl/sram_controller.sv
// Pipeline-side controller for a 16-bit asynchronous SRAM: each 32-bit load/store
// becomes two half-word accesses followed by two settle cycles, stalling the pipeline via ready.
module sram_controller (
   input  logic        clk,
   input  logic        rst,
   input  logic        write_en,
   input  logic        read_en,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   inout  wire  [15:0] SRAM_DQ,
   output logic [17:0] SRAM_ADDR,
   output logic        SRAM_WE_N,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N,
   output logic        SRAM_CE_N,
   output logic        SRAM_OE_N
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOW   = 3'd1;
   localparam logic [2:0] S_HIGH  = 3'd2;
   localparam logic [2:0] S_WAIT1 = 3'd3;
   localparam logic [2:0] S_WAIT2 = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   logic [2:0]  r_state;
   logic [2:0]  w_next;
   logic        r_is_write;
   logic [16:0] r_word;
   logic [31:0] r_wdata;
   logic [31:0] r_read_data;
   logic        w_req;
   logic [18:0] w_eff;
   logic        w_drive;
   logic [15:0] w_dq_out;
   logic        w_unused;

   assign w_req    = write_en | read_en;
   // Data region begins at byte 1024; only the bits that reach the 18-bit half-word bus matter.
   assign w_eff    = address[18:0] - 19'd1024;
   assign w_unused = ^{address[31:19], w_eff[1:0]};

   // Next-state: only IDLE looks at requests, everything after LOW is a fixed sequence.
   always_comb begin
      w_next = S_IDLE;
      case (r_state)
         S_IDLE:  w_next = w_req ? S_LOW : S_IDLE;
         S_LOW:   w_next = S_HIGH;
         S_HIGH:  w_next = S_WAIT1;
         S_WAIT1: w_next = S_WAIT2;
         S_WAIT2: w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // State, request latch and read-data capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_is_write  <= 1'b0;
         r_word      <= 17'd0;
         r_wdata     <= 32'd0;
         r_read_data <= 32'd0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && w_req) begin
            r_is_write <= write_en;
            r_word     <= w_eff[18:2];
            r_wdata    <= write_data;
         end
         if (r_state == S_LOW && !r_is_write) begin
            r_read_data[15:0] <= SRAM_DQ;
         end
         if (r_state == S_HIGH && !r_is_write) begin
            r_read_data[31:16] <= SRAM_DQ;
         end
      end
   end

   // SRAM strobes and ready; reset forces the bus quiet so an aborted write stops at once.
   always_comb begin
      SRAM_ADDR = 18'd0;
      SRAM_WE_N = 1'b1;
      w_drive   = 1'b0;
      w_dq_out  = 16'd0;
      ready     = 1'b0;
      if (rst) begin
         ready = 1'b1;
      end else begin
         case (r_state)
            S_IDLE:  ready = ~w_req;
            S_LOW: begin
               SRAM_ADDR = {r_word, 1'b0};
               SRAM_WE_N = ~r_is_write;
               w_drive   = r_is_write;
               w_dq_out  = r_wdata[15:0];
            end
            S_HIGH: begin
               SRAM_ADDR = {r_word, 1'b1};
               SRAM_WE_N = ~r_is_write;
               w_drive   = r_is_write;
               w_dq_out  = r_wdata[31:16];
            end
            S_WAIT1: ready = 1'b0;
            S_WAIT2: ready = 1'b0;
            S_DONE:  ready = 1'b1;
            default: ready = 1'b0;
         endcase
      end
   end

   assign SRAM_DQ   = w_drive ? w_dq_out : 16'hzzzz;
   assign read_data = r_read_data;
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;
   assign SRAM_CE_N = 1'b0;
   assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: SRAM model, latency-counting reference model
// compared every cycle, plus literal expectations for the key scenarios.
module tb_sram_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        write_en, read_en;
   logic [31:0] address, write_data;
   wire  [31:0] read_data;
   wire         ready;
   wire  [15:0] sram_dq;
   wire  [17:0] sram_addr;
   wire         we_n, ub_n, lb_n, ce_n, oe_n;

   always #5 clk = ~clk;

   sram_controller dut (
      .clk(clk), .rst(rst), .write_en(write_en), .read_en(read_en),
      .address(address), .write_data(write_data), .read_data(read_data),
      .ready(ready), .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(we_n),
      .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n)
   );

   logic [15:0] sram    [0:1023];
   logic [15:0] ref_mem [0:1023];
   int checks = 0, errors = 0, bad_writes = 0;
   logic chk_en = 1'b0;

   function automatic logic [15:0] init_val(input int a);
      return 16'hA500 | 16'(a & 255);
   endfunction

   initial begin
      for (int a = 0; a < 1024; a++) begin
         sram[a]    = init_val(a);
         ref_mem[a] = init_val(a);
      end
   end

   // SRAM device: drives the bus whenever it is not being written.
   assign sram_dq = we_n ? sram[sram_addr[9:0]] : 16'hzzzz;
   always @(posedge clk) begin
      if (!we_n) begin
         if (sram_addr >= 18'd512) bad_writes++;
         sram[sram_addr[9:0]] = sram_dq;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: m_age counts cycles since acceptance (0 = idle, 5 = ready-high cycle).
   int          m_age = 0;
   logic        m_wr  = 1'b0;
   int          m_idx = 0;
   logic [31:0] m_wd  = 32'd0;
   logic [31:0] m_rd  = 32'd0;
   logic [18:0] m_eff;

   always @(posedge clk) begin
      if (rst) begin
         m_age = 0;
         m_rd  = 32'd0;
      end else if (m_age == 0) begin
         if (write_en || read_en) begin
            m_age = 1;
            m_wr  = write_en;
            m_eff = address[18:0] - 19'd1024;
            m_idx = int'(m_eff) / 4;
            m_wd  = write_data;
         end
      end else if (m_age == 1) begin
         if (m_wr) ref_mem[(m_idx * 2) & 1023] = m_wd[15:0];
         else      m_rd[15:0] = ref_mem[(m_idx * 2) & 1023];
         m_age = 2;
      end else if (m_age == 2) begin
         if (m_wr) ref_mem[(m_idx * 2 + 1) & 1023] = m_wd[31:16];
         else      m_rd[31:16] = ref_mem[(m_idx * 2 + 1) & 1023];
         m_age = 3;
      end else if (m_age < 5) begin
         m_age = m_age + 1;
      end else begin
         m_age = 0;
      end
   end

   logic        e_ready, e_we_n;
   logic [17:0] e_addr;
   logic [15:0] e_dq;

   always @(negedge clk) begin
      if (chk_en) begin
         e_ready = rst ? 1'b1 : (m_age == 0 ? !(write_en || read_en) : (m_age == 5));
         e_we_n  = rst ? 1'b1 : !(m_wr && (m_age == 1 || m_age == 2));
         e_addr  = (rst || !(m_age == 1 || m_age == 2)) ? 18'd0 : 18'(m_idx * 2 + m_age - 1);
         e_dq    = (m_age == 1) ? m_wd[15:0] : m_wd[31:16];
         chk("ready", {31'd0, ready}, {31'd0, e_ready});
         chk("we_n", {31'd0, we_n}, {31'd0, e_we_n});
         chk("sram_addr", {14'd0, sram_addr}, {14'd0, e_addr});
         chk("read_data", read_data, m_rd);
         chk("static_pins", {28'd0, ub_n, lb_n, ce_n, oe_n}, 32'd0);
         if (!e_we_n) chk("dq_write", {16'd0, sram_dq}, {16'd0, e_dq});
      end
   end

   task automatic do_access(input logic we, input logic re, input logic [31:0] a,
                            input logic [31:0] wd, input logic mid,
                            output logic [5:0] pat, output logic [31:0] rd);
      write_en = we; read_en = re; address = a; write_data = wd;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         pat[5-i] = ready;
         rd       = read_data;
         @(posedge clk); #1;
         if (i == 0) begin write_en = 1'b0; read_en = 1'b0; end
         if (mid && i == 2) begin address = 32'd2048; write_data = 32'd0; write_en = 1'b1; end
         if (mid && i == 3) write_en = 1'b0;
      end
   endtask

   logic [5:0]  pat, pat2;
   logic [31:0] rd, rd2;

   initial begin
      rst = 1'b1; write_en = 1'b0; read_en = 1'b0; address = 32'd0; write_data = 32'd0;
      @(posedge clk); #1;
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_ready", {31'd0, ready}, 32'd1);
      chk("rst_rdata", read_data, 32'd0);
      chk("rst_addr", {14'd0, sram_addr}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // write then read back
      do_access(1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, 1'b0, pat, rd);
      chk("wr_ready_pattern", {26'd0, pat}, {26'd0, 6'b000001});
      chk("wr_lo", {16'd0, sram[4]}, 32'h0000BEEF);
      chk("wr_hi", {16'd0, sram[5]}, 32'h0000DEAD);
      do_access(1'b0, 1'b1, 32'd1032, 32'd0, 1'b0, pat, rd);
      chk("rd_ready_pattern", {26'd0, pat}, {26'd0, 6'b000001});
      chk("rd_data", rd, 32'hDEADBEEF);

      // both enables: write wins, read_data untouched
      do_access(1'b1, 1'b1, 32'd1024, 32'h12345678, 1'b0, pat, rd);
      chk("both_rdata_keep", rd, 32'hDEADBEEF);
      chk("both_lo", {16'd0, sram[0]}, 32'h00005678);
      chk("both_hi", {16'd0, sram[1]}, 32'h00001234);

      // inputs change during WAIT1
      do_access(1'b1, 1'b0, 32'd1036, 32'hCAFEF00D, 1'b1, pat, rd);
      chk("mid_lo", {16'd0, sram[6]}, 32'h0000F00D);
      chk("mid_hi", {16'd0, sram[7]}, 32'h0000CAFE);
      chk("mid_idx256", {sram[513], sram[512]}, 32'hA501A500);
      do_access(1'b0, 1'b1, 32'd1036, 32'd0, 1'b0, pat, rd);
      chk("mid_readback", rd, 32'hCAFEF00D);

      // back-to-back reads
      do_access(1'b0, 1'b1, 32'd1024, 32'd0, 1'b0, pat, rd);
      do_access(1'b0, 1'b1, 32'd1028, 32'd0, 1'b0, pat2, rd2);
      chk("b2b_pattern", {20'd0, pat, pat2}, {20'd0, 12'b000001000001});
      chk("b2b_rd1", rd, 32'h12345678);
      chk("b2b_rd2", rd2, 32'hA503A502);

      // reset during HIGH of a write to 1040
      write_en = 1'b1; address = 32'd1040; write_data = 32'h11112222;
      @(posedge clk); #1;
      write_en = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rstmid_we_n", {31'd0, we_n}, 32'd1);
      chk("rstmid_ready", {31'd0, ready}, 32'd1);
      chk("rstmid_addr", {14'd0, sram_addr}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("after_rst_rdata", read_data, 32'd0);
      chk("after_rst_ready", {31'd0, ready}, 32'd1);
      chk("after_rst_we_n", {31'd0, we_n}, 32'd1);
      chk("rstmid_hi_unwritten", {16'd0, sram[9]}, 32'h0000A509);

      // idle stretch
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_ready", {31'd0, ready}, 32'd1);
         chk("idle_we_n", {31'd0, we_n}, 32'd1);
         chk("idle_addr", {14'd0, sram_addr}, 32'd0);
      end

      for (int a = 0; a < 16; a++) chk("mem_vs_model", {16'd0, sram[a]}, {16'd0, ref_mem[a]});
      chk("stray_writes", bad_writes, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  pipeline clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 write_en  input  1  store request from the EXE→MEM pipeline register.
REQ-005 read_en  input  1  load request from the EXE→MEM pipeline register.
REQ-006 address  input  32  byte address (ALU result); data region starts at 1024.
REQ-007 write_data  input  32  store data (val_Rm).
REQ-008 read_data  output  32  load result to the MEM→WB pipeline register.
REQ-009 ready  output  1  low = access in progress; pipeline freezes all stages while low.
REQ-010 SRAM_DQ  inout  16  external SRAM data bus.
REQ-011 SRAM_ADDR  output  18  external SRAM half-word address.
REQ-012 SRAM_WE_N  output  1  active-low SRAM write strobe.
REQ-013 SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  output  1 each  held constant 0.

Function
REQ-014 The FSM SHALL have states IDLE, LOW, HIGH, WAIT1, WAIT2 and DONE.
REQ-015 IDLE: if write_en or read_en is 1, go to LOW; otherwise stay in IDLE.
REQ-016 State sequence after LOW SHALL be unconditional: LOW→HIGH→WAIT1→WAIT2→DONE→IDLE.
REQ-017 In IDLE with a request, the block SHALL register the operation (write has priority when both enables are 1), the effective address (address − 1024), and write_data. Later input changes SHALL NOT affect the access in progress.
REQ-018 The word index SHALL be eff[18:2]. SRAM_ADDR SHALL be {eff[18:2],1'b0} in LOW and {eff[18:2],1'b1} in HIGH, and 0 in all other states. eff[1:0] SHALL be ignored.
REQ-019 Write, LOW: SRAM_WE_N=0 and SRAM_DQ=wdata[15:0]. Write, HIGH: SRAM_WE_N=0 and SRAM_DQ=wdata[31:16].
REQ-020 SRAM_WE_N SHALL be 1 in every other state and on reads.
REQ-021 SRAM_DQ SHALL be high-Z whenever the block is not driving a write.
REQ-022 Read: at the end of LOW, the block SHALL capture SRAM_DQ into read_data[15:0]. At the end of HIGH, it SHALL capture SRAM_DQ into read_data[31:16].
REQ-023 read_data SHALL hold its value until the next read overwrites it. Writes SHALL NOT change read_data.
REQ-024 ready (combinational) SHALL be:
  - 1 in IDLE with no request;
  - 0 in IDLE with a request;
  - 0 in LOW, HIGH, WAIT1 and WAIT2;
  - 1 in DONE.
REQ-025 Latency: a request first seen in cycle N SHALL give ready=0 in cycles N..N+4 and ready=1 in cycle N+5. For a read, read_data SHALL be valid in cycle N+5.
REQ-026 Back-to-back: if a request is present in IDLE in the cycle after DONE, it SHALL start immediately. No idle gap is required beyond that one IDLE cycle.
REQ-027 No request SHALL be accepted in any state other than IDLE.

Reset
REQ-028 While rst=1 at a clock edge, the next state SHALL be IDLE, read_data SHALL be 0, and the latched op, address and data registers SHALL be 0.
REQ-029 During reset the outputs SHALL be: SRAM_WE_N=1, SRAM_DQ high-Z, SRAM_ADDR=0, ready=1.
REQ-030 Reset asserted mid-access SHALL abort the access with no further SRAM writes. After reset, the half-written word is undefined and is not repaired.

Verification
REQ-031 Write then read:
  - write_en=1, address=1032, write_data=0xDEADBEEF → SRAM[0x000004]=0xBEEF, SRAM[0x000005]=0xDEAD.
  - ready low for exactly 5 cycles.
  - Then read_en=1 at address=1032 → read_data=0xDEADBEEF in the ready-high cycle.
REQ-032 Both enables high: write_en=1 and read_en=1, address=1024, write_data=0x12345678 → only a write occurs (SRAM[0]=0x5678, SRAM[1]=0x1234) and read_data is unchanged.
REQ-033 Input change mid-access: change address to 2048 and write_data to 0 during WAIT1 → the access completes with the originally latched values and no SRAM activity at index 256.
REQ-034 Back-to-back: two consecutive reads at 1024 and 1028 → the ready pattern is 0,0,0,0,0,1,0,0,0,0,0,1 and each read_data matches memory.
REQ-035 Reset mid-write: rst=1 during HIGH of a write to 1040 → next cycle IDLE, SRAM_WE_N=1, DQ high-Z, read_data=0, ready=1, and the SRAM high half at index 9 is not written.
REQ-036 Idle: no enables for 20 cycles → ready=1, SRAM_WE_N=1 and SRAM_ADDR=0 throughout.
